// File: rtl/sha256_block_padder.sv
// -----------------------------------------------------------------------------
// sha256_block_padder
//
// Reads NUM_OF_WORDS message words from the shared word-addressed memory and
// streams them, followed by SHA-256 padding (0x80000000, zero fill, 64-bit
// big-endian bit length), as complete 16-word blocks over valid/ready.
//
// Ports
//   clk            in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   begins one message; sampled only in IDLE
//   message_addr   in   [15:0] word address of message word 0
//   mem_clk        out  copy of clk for the memory
//   mem_we         out  always 0 (read-only master)
//   mem_addr       out  [15:0] registered read address
//   mem_read_data  in   [31:0] read data; sampled on the edge after the one
//                       that registered mem_addr
//   out_valid      out  out_word is valid
//   out_ready      in   consumer accepts the word on this edge if out_valid
//   out_word       out  [31:0] message or padding word
//   out_block_last out  out_word is word 15 of a block
//   out_msg_last   out  out_word is the final word of the message
//   busy           out  high from the start edge until the final transfer
//   done           out  one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module sha256_block_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_block_last,
    output logic        out_msg_last,
    output logic        busy,
    output logic        done
);

    localparam int          NUM_BLOCKS  = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam int          TOTAL_WORDS = 16 * NUM_BLOCKS;
    localparam logic [63:0] BIT_LEN     = 64'(NUM_OF_WORDS) * 64'd32;

    // 16-bit copies of the index boundaries so comparisons stay same-width
    localparam logic [15:0] IDX_PAD    = 16'(NUM_OF_WORDS);
    localparam logic [15:0] IDX_END    = 16'(TOTAL_WORDS);
    localparam logic [15:0] IDX_LAST   = 16'(TOTAL_WORDS - 1);
    localparam logic [15:0] IDX_LEN_HI = 16'(TOTAL_WORDS - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t      state;
    logic [15:0] ri;          // next word index to issue
    logic [15:0] oi;          // index of the word at the FIFO head
    logic [15:0] base_addr;   // message_addr captured at start

    // One-deep issue pipeline: a word issued on edge E is pushed on E+1.
    // Generated words ride the same stage so FIFO order is index order.
    logic        pend;
    logic        pend_gen;
    logic [31:0] pend_word;
    logic        pend_bl;
    logic        pend_ml;

    // Second FIFO entry; the first entry is the out_* register set itself.
    logic        e1_valid;
    logic [31:0] e1_word;
    logic        e1_bl;
    logic        e1_ml;

    logic        xfer;
    logic        last_xfer;
    logic [1:0]  occ;
    logic [2:0]  committed;
    logic        issue;
    logic [31:0] gen_word;
    logic [31:0] push_word;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (oi == IDX_LAST);
    assign occ       = {1'b0, out_valid} + {1'b0, e1_valid};

    // Slots already promised after this edge: stored words plus the word in
    // flight, minus the one leaving now. Counting the departing word is what
    // lets a 2-entry FIFO sustain one word per cycle without risking overflow.
    assign committed = {1'b0, occ} + {2'b00, pend} - {2'b00, xfer};
    assign issue     = (state == RUN) && (ri != IDX_END) && (committed < 3'd2);

    assign push_word = pend_gen ? pend_word : mem_read_data;

    // Padding word for a non-memory index. IDX_PAD never collides with the
    // length indices because there are always at least 3 padding words.
    always_comb begin
        gen_word = 32'h0000_0000;
        if (ri == IDX_PAD)
            gen_word = 32'h8000_0000;
        else if (ri == IDX_LEN_HI)
            gen_word = BIT_LEN[63:32];
        else if (ri == IDX_LAST)
            gen_word = BIT_LEN[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ri             <= 16'd0;
            oi             <= 16'd0;
            base_addr      <= 16'd0;
            mem_addr       <= 16'd0;
            pend           <= 1'b0;
            pend_gen       <= 1'b0;
            pend_word      <= 32'd0;
            pend_bl        <= 1'b0;
            pend_ml        <= 1'b0;
            e1_valid       <= 1'b0;
            e1_word        <= 32'd0;
            e1_bl          <= 1'b0;
            e1_ml          <= 1'b0;
            out_valid      <= 1'b0;
            out_word       <= 32'd0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= issue;

            // ---------------- issue stage ----------------
            if (issue) begin
                ri      <= ri + 16'd1;
                pend_bl <= (ri[3:0] == 4'hF);
                pend_ml <= (ri == IDX_LAST);
                if (ri < IDX_PAD) begin
                    mem_addr <= base_addr + ri;   // wraps modulo 2^16
                    pend_gen <= 1'b0;
                end else begin
                    pend_gen  <= 1'b1;
                    pend_word <= gen_word;
                end
            end

            // ---------------- FIFO ----------------
            if (xfer)
                oi <= oi + 16'd1;

            case ({xfer, pend})
                2'b11: begin
                    if (e1_valid) begin
                        out_word       <= e1_word;
                        out_block_last <= e1_bl;
                        out_msg_last   <= e1_ml;
                        e1_word        <= push_word;
                        e1_bl          <= pend_bl;
                        e1_ml          <= pend_ml;
                    end else begin
                        out_word       <= push_word;
                        out_block_last <= pend_bl;
                        out_msg_last   <= pend_ml;
                    end
                end
                2'b10: begin
                    // Head word stays put when nothing is behind it; only
                    // out_valid drops.
                    out_valid <= e1_valid;
                    e1_valid  <= 1'b0;
                    if (e1_valid) begin
                        out_word       <= e1_word;
                        out_block_last <= e1_bl;
                        out_msg_last   <= e1_ml;
                    end
                end
                2'b01: begin
                    if (!out_valid) begin
                        out_valid      <= 1'b1;
                        out_word       <= push_word;
                        out_block_last <= pend_bl;
                        out_msg_last   <= pend_ml;
                    end else begin
                        e1_valid <= 1'b1;
                        e1_word  <= push_word;
                        e1_bl    <= pend_bl;
                        e1_ml    <= pend_ml;
                    end
                end
                default: ;
            endcase

            // ---------------- control ----------------
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        ri        <= 16'd0;
                        oi        <= 16'd0;
                        base_addr <= message_addr;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && (ri == IDX_LAST))
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (last_xfer) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
